// File: rtl/bp_clint_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_clint_arbiter_if: requester-side and CLINT-side bundle of the arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface bp_clint_arbiter_if #(
  parameter int num_req_p   = 4,
  parameter int msg_width_p = 32
);
  logic [num_req_p*msg_width_p-1:0] req_cmd_i;
  logic [num_req_p-1:0]             req_cmd_v_i;
  logic [num_req_p-1:0]             req_cmd_ready_o;
  logic [msg_width_p-1:0]           req_resp_o;
  logic [num_req_p-1:0]             req_resp_v_o;
  logic [num_req_p-1:0]             req_resp_yumi_i;
  logic [msg_width_p-1:0]           clint_cmd_o;
  logic                             clint_cmd_v_o;
  logic                             clint_cmd_ready_i;
  logic [msg_width_p-1:0]           clint_resp_i;
  logic                             clint_resp_v_i;
  logic                             clint_resp_yumi_o;
  logic                             error_o;

  // master = the surrounding system (requesters + slice), slave = the arbiter
  modport master (
    output req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
    output clint_cmd_ready_i, clint_resp_i, clint_resp_v_i,
    input  req_cmd_ready_o, req_resp_o, req_resp_v_o,
    input  clint_cmd_o, clint_cmd_v_o, clint_resp_yumi_o, error_o
  );

  modport slave (
    input  req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
    input  clint_cmd_ready_i, clint_resp_i, clint_resp_v_i,
    output req_cmd_ready_o, req_resp_o, req_resp_v_o,
    output clint_cmd_o, clint_cmd_v_o, clint_resp_yumi_o, error_o
  );
endinterface
`default_nettype wire

// File: rtl/bp_clint_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_clint_arbiter: round-robin CLINT command arbiter with in-order response steering
// Revision: 1.0
// ---------------------------------------------------------------------------
module bp_clint_arbiter #(
  parameter int num_req_p         = 4,
  parameter int msg_width_p       = 32,
  parameter int max_outstanding_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bp_clint_arbiter_if.slave    bus
);
  localparam int lg_num_req_lp = $clog2(num_req_p);
  localparam int ptr_w_lp      = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp      = $clog2(max_outstanding_p + 1);

  logic [cnt_w_lp-1:0]      count;
  logic [lg_num_req_lp-1:0] rr_ptr;
  logic [lg_num_req_lp-1:0] tag_mem [max_outstanding_p];
  logic [ptr_w_lp-1:0]      rd_ptr;
  logic [ptr_w_lp-1:0]      wr_ptr;
  logic                     error_r;

  logic                     run;
  logic                     avail;
  logic                     any_v;
  logic                     found;
  logic [lg_num_req_lp-1:0] grant;
  logic [lg_num_req_lp-1:0] head;
  logic                     empty;
  logic                     cmd_v;
  logic                     issue;
  logic                     yumi;
  logic                     retire;
  logic                     stray;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && bus.req_cmd_v_i[(int'(rr_ptr) + i) % num_req_p]) begin
        grant = lg_num_req_lp'((int'(rr_ptr) + i) % num_req_p);
        found = 1'b1;
      end
    end
  end

  // Every handshake output is forced low while reset is held.
  assign run    = reset_i;
  assign avail  = (count < cnt_w_lp'(max_outstanding_p));
  assign any_v  = |bus.req_cmd_v_i;
  assign cmd_v  = run & any_v & avail;
  assign issue  = cmd_v & bus.clint_cmd_ready_i;

  assign empty  = (count == '0);
  assign head   = tag_mem[rd_ptr];
  assign yumi   = run & bus.clint_resp_v_i & (empty | bus.req_resp_yumi_i[head]);
  assign retire = yumi & ~empty;
  assign stray  = run & bus.clint_resp_v_i & empty;

  assign bus.clint_cmd_v_o     = cmd_v;
  assign bus.clint_cmd_o       = bus.req_cmd_i[int'(grant)*msg_width_p +: msg_width_p];
  assign bus.req_cmd_ready_o   = (cmd_v & bus.clint_cmd_ready_i)
                               ? ({{(num_req_p-1){1'b0}}, 1'b1} << grant) : '0;
  assign bus.req_resp_o        = bus.clint_resp_i;
  assign bus.req_resp_v_o      = (run & ~empty & bus.clint_resp_v_i)
                               ? ({{(num_req_p-1){1'b0}}, 1'b1} << head) : '0;
  assign bus.clint_resp_yumi_o = yumi;
  assign bus.error_o           = error_r;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count   <= '0;
      rr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      error_r <= 1'b0;
      for (int i = 0; i < max_outstanding_p; i++) tag_mem[i] <= '0;
    end else begin
      if (issue) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= ptr_inc(wr_ptr);
        rr_ptr          <= (grant == lg_num_req_lp'(num_req_p - 1)) ? '0 : grant + lg_num_req_lp'(1);
      end
      if (retire) rd_ptr <= ptr_inc(rd_ptr);
      // Occupancy of the tag queue doubles as the credit count.
      if (issue && !retire)      count <= count + cnt_w_lp'(1);
      else if (retire && !issue) count <= count - cnt_w_lp'(1);
      if (stray) error_r <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bp_clint_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bp_clint_arbiter: directed and random checks against a queue-based model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bp_clint_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int M = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_clint_arbiter_if #(.num_req_p(N), .msg_width_p(W)) bus ();

  bp_clint_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(M)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int passed = 0;

  // Model: owners of outstanding commands in issue order, plus next-priority index.
  int rr_m;
  int q_m[$];
  bit err_m;

  logic         e_cmd_v;
  logic [N-1:0] e_ready;
  logic [N-1:0] e_resp_v;
  logic         e_yumi;
  int           e_grant;
  logic [W-1:0] e_cmd;

  function automatic void compute_expect();
    int sz = q_m.size();
    e_grant = 0;
    for (int i = N - 1; i >= 0; i--)
      if (bus.req_cmd_v_i[(rr_m + i) % N]) e_grant = (rr_m + i) % N;
    e_cmd_v = (|bus.req_cmd_v_i) && (sz < M);
    e_ready = (e_cmd_v && bus.clint_cmd_ready_i) ? (N'(1) << e_grant) : '0;
    e_cmd   = bus.req_cmd_i[e_grant*W +: W];
    if (sz > 0) begin
      e_resp_v = bus.clint_resp_v_i ? (N'(1) << q_m[0]) : '0;
      e_yumi   = bus.clint_resp_v_i && bus.req_resp_yumi_i[q_m[0]];
    end else begin
      e_resp_v = '0;
      e_yumi   = bus.clint_resp_v_i;
    end
  endfunction

  function automatic void model_update();
    int sz = q_m.size();
    if (sz > 0 && e_yumi) void'(q_m.pop_front());
    if (sz == 0 && bus.clint_resp_v_i) err_m = 1'b1;
    if (e_cmd_v && bus.clint_cmd_ready_i) begin
      q_m.push_back(e_grant);
      rr_m = (e_grant + 1) % N;
    end
  endfunction

  task automatic idle();
    bus.req_cmd_i         = '0;
    bus.req_cmd_v_i       = '0;
    bus.req_resp_yumi_i   = '0;
    bus.clint_cmd_ready_i = 1'b0;
    bus.clint_resp_i      = '0;
    bus.clint_resp_v_i    = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    compute_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    rr_m = 0; q_m.delete(); err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_cmd_v_i = '1; bus.clint_cmd_ready_i = 1'b1;
    bus.clint_resp_v_i = 1'b1; bus.req_resp_yumi_i = '1;
    #2;
    checks++; if (bus.clint_cmd_v_o !== 1'b0) $display("FAIL reset_cmd_v: got %0b want 0", bus.clint_cmd_v_o); else passed++;
    checks++; if (bus.req_cmd_ready_o !== 4'b0) $display("FAIL reset_ready: got %b want 0000", bus.req_cmd_ready_o); else passed++;
    checks++; if (bus.req_resp_v_o !== 4'b0) $display("FAIL reset_resp_v: got %b want 0000", bus.req_resp_v_o); else passed++;
    checks++; if (bus.clint_resp_yumi_o !== 1'b0) $display("FAIL reset_yumi: got %0b want 0", bus.clint_resp_yumi_o); else passed++;
    checks++; if (bus.error_o !== 1'b0) $display("FAIL reset_error: got %0b want 0", bus.error_o); else passed++;
    checks++; if (dut.count !== '0) $display("FAIL reset_count: got %0d want 0", dut.count); else passed++;
    idle();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.req_cmd_i = {$urandom, 32'h0200_BFF8, $urandom, $urandom};
    bus.req_cmd_v_i = 4'b0100; bus.clint_cmd_ready_i = 1'b1;
    sample();
    checks++; if (bus.clint_cmd_v_o !== 1'b1) $display("FAIL single_cmd_v: got %0b want 1", bus.clint_cmd_v_o); else passed++;
    checks++; if (bus.req_cmd_ready_o !== 4'b0100) $display("FAIL single_ready: got %b want 0100", bus.req_cmd_ready_o); else passed++;
    checks++; if (bus.clint_cmd_o !== 32'h0200_BFF8) $display("FAIL single_cmd: got %h want 0200bff8", bus.clint_cmd_o); else passed++;
    tick();
    bus.req_cmd_v_i = '0; bus.clint_resp_i = 32'h1234_5678;
    bus.clint_resp_v_i = 1'b1; bus.req_resp_yumi_i = 4'b0100;
    sample();
    checks++; if (bus.req_resp_v_o !== 4'b0100) $display("FAIL single_resp_v: got %b want 0100", bus.req_resp_v_o); else passed++;
    checks++; if (bus.req_resp_o !== 32'h1234_5678) $display("FAIL single_resp: got %h want 12345678", bus.req_resp_o); else passed++;
    checks++; if (bus.clint_resp_yumi_o !== 1'b1) $display("FAIL single_yumi: got %0b want 1", bus.clint_resp_yumi_o); else passed++;
    tick();
    idle();
    sample();
    checks++; if (dut.count !== '0) $display("FAIL single_count: got %0d want 0", dut.count); else passed++;
    checks++; if (dut.rr_ptr !== 2'd3) $display("FAIL single_rr: got %0d want 3", dut.rr_ptr); else passed++;
    tick();
  endtask

  task automatic test_rr_all();
    do_reset();
    bus.req_cmd_v_i = '1; bus.clint_cmd_ready_i = 1'b1; bus.req_resp_yumi_i = '1;
    for (int c = 0; c < 6; c++) begin
      bus.req_cmd_i = {$urandom, $urandom, $urandom, $urandom};
      bus.clint_resp_v_i = (c > 0);
      bus.clint_resp_i = 32'hA000_0000 + c;
      sample();
      checks++; if (bus.req_cmd_ready_o !== (N'(1) << (c % 4))) $display("FAIL rr_grant%0d: got %b want %b", c, bus.req_cmd_ready_o, N'(1) << (c % 4)); else passed++;
      checks++; if (bus.clint_cmd_o !== bus.req_cmd_i[(c % 4)*W +: W]) $display("FAIL rr_cmd%0d: got %h want %h", c, bus.clint_cmd_o, bus.req_cmd_i[(c % 4)*W +: W]); else passed++;
      if (c > 0) begin
        checks++; if (bus.req_resp_v_o !== (N'(1) << ((c - 1) % 4))) $display("FAIL rr_resp%0d: got %b want %b", c, bus.req_resp_v_o, N'(1) << ((c - 1) % 4)); else passed++;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_credit_block();
    do_reset();
    bus.req_cmd_v_i = 4'b0001; bus.clint_cmd_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++; if (bus.clint_cmd_v_o !== 1'b1) $display("FAIL credit_issue%0d: got %0b want 1", c, bus.clint_cmd_v_o); else passed++;
      tick();
    end
    sample();
    checks++; if (bus.clint_cmd_v_o !== 1'b0) $display("FAIL credit_full_v: got %0b want 0", bus.clint_cmd_v_o); else passed++;
    checks++; if (bus.req_cmd_ready_o !== 4'b0) $display("FAIL credit_full_ready: got %b want 0000", bus.req_cmd_ready_o); else passed++;
    checks++; if (dut.count !== 2'd2) $display("FAIL credit_count2: got %0d want 2", dut.count); else passed++;
    tick();
    bus.clint_resp_v_i = 1'b1; bus.req_resp_yumi_i = 4'b0001;
    sample();
    checks++; if (bus.clint_cmd_v_o !== 1'b0) $display("FAIL credit_simul_v: got %0b want 0", bus.clint_cmd_v_o); else passed++;
    checks++; if (bus.clint_resp_yumi_o !== 1'b1) $display("FAIL credit_simul_yumi: got %0b want 1", bus.clint_resp_yumi_o); else passed++;
    tick();
    bus.clint_resp_v_i = 1'b0; bus.req_resp_yumi_i = '0;
    sample();
    checks++; if (bus.clint_cmd_v_o !== 1'b1) $display("FAIL credit_reissue: got %0b want 1", bus.clint_cmd_v_o); else passed++;
    checks++; if (dut.count !== 2'd1) $display("FAIL credit_count1: got %0d want 1", dut.count); else passed++;
    tick();
    idle();
    sample();
    checks++; if (dut.count !== 2'd2) $display("FAIL credit_count_back: got %0d want 2", dut.count); else passed++;
    tick();
  endtask

  task automatic test_yumi_owner();
    do_reset();
    bus.req_cmd_v_i = 4'b0010; bus.clint_cmd_ready_i = 1'b1;
    sample();
    tick();
    idle();
    bus.clint_resp_v_i = 1'b1; bus.req_resp_yumi_i = 4'b1101; bus.clint_resp_i = 32'hC0FF_EE00;
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++; if (bus.clint_resp_yumi_o !== 1'b0) $display("FAIL owner_nonowner_yumi%0d: got %0b want 0", c, bus.clint_resp_yumi_o); else passed++;
      checks++; if (bus.req_resp_v_o !== 4'b0010) $display("FAIL owner_resp_v%0d: got %b want 0010", c, bus.req_resp_v_o); else passed++;
      checks++; if (dut.count !== 2'd1) $display("FAIL owner_hold_count%0d: got %0d want 1", c, dut.count); else passed++;
      tick();
    end
    bus.req_resp_yumi_i = 4'b0010;
    sample();
    checks++; if (bus.clint_resp_yumi_o !== 1'b1) $display("FAIL owner_yumi: got %0b want 1", bus.clint_resp_yumi_o); else passed++;
    tick();
    idle();
    sample();
    checks++; if (dut.count !== '0) $display("FAIL owner_pop_count: got %0d want 0", dut.count); else passed++;
    tick();
  endtask

  task automatic test_error_and_reset();
    do_reset();
    bus.clint_resp_v_i = 1'b1;
    sample();
    checks++; if (bus.req_resp_v_o !== 4'b0) $display("FAIL err_resp_v: got %b want 0000", bus.req_resp_v_o); else passed++;
    checks++; if (bus.clint_resp_yumi_o !== 1'b1) $display("FAIL err_drain: got %0b want 1", bus.clint_resp_yumi_o); else passed++;
    checks++; if (bus.error_o !== 1'b0) $display("FAIL err_early: got %0b want 0", bus.error_o); else passed++;
    tick();
    bus.clint_resp_v_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      checks++; if (bus.error_o !== 1'b1) $display("FAIL err_sticky%0d: got %0b want 1", c, bus.error_o); else passed++;
      tick();
    end
    bus.req_cmd_v_i = 4'b0001; bus.clint_cmd_ready_i = 1'b1;
    sample(); tick();
    sample(); tick();
    sample();
    checks++; if (dut.count !== 2'd2) $display("FAIL err_outstanding: got %0d want 2", dut.count); else passed++;
    #1;
    bus.clint_resp_v_i = 1'b1; bus.req_resp_yumi_i = '1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.clint_cmd_v_o !== 1'b0) $display("FAIL rst_cmd_v: got %0b want 0", bus.clint_cmd_v_o); else passed++;
    checks++; if (bus.req_resp_v_o !== 4'b0) $display("FAIL rst_resp_v: got %b want 0000", bus.req_resp_v_o); else passed++;
    checks++; if (bus.clint_resp_yumi_o !== 1'b0) $display("FAIL rst_yumi: got %0b want 0", bus.clint_resp_yumi_o); else passed++;
    checks++; if (bus.error_o !== 1'b0) $display("FAIL rst_error: got %0b want 0", bus.error_o); else passed++;
    checks++; if (dut.count !== '0) $display("FAIL rst_count: got %0d want 0", dut.count); else passed++;
    checks++; if (dut.rr_ptr !== '0) $display("FAIL rst_rr: got %0d want 0", dut.rr_ptr); else passed++;
    idle();
    rr_m = 0; q_m.delete(); err_m = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req_cmd_i         = {$urandom, $urandom, $urandom, $urandom};
      bus.req_cmd_v_i       = N'($urandom);
      bus.clint_cmd_ready_i = ($urandom_range(0, 3) != 0);
      bus.clint_resp_i      = $urandom;
      bus.clint_resp_v_i    = (q_m.size() > 0) && ($urandom_range(0, 2) != 0);
      bus.req_resp_yumi_i   = N'($urandom);
      sample();
      checks++; if (bus.clint_cmd_v_o !== e_cmd_v) $display("FAIL rnd_cmd_v@%0d: got %0b want %0b", c, bus.clint_cmd_v_o, e_cmd_v); else passed++;
      checks++; if (bus.req_cmd_ready_o !== e_ready) $display("FAIL rnd_ready@%0d: got %b want %b", c, bus.req_cmd_ready_o, e_ready); else passed++;
      if (e_cmd_v) begin
        checks++; if (bus.clint_cmd_o !== e_cmd) $display("FAIL rnd_cmd@%0d: got %h want %h", c, bus.clint_cmd_o, e_cmd); else passed++;
      end
      checks++; if (bus.req_resp_v_o !== e_resp_v) $display("FAIL rnd_resp_v@%0d: got %b want %b", c, bus.req_resp_v_o, e_resp_v); else passed++;
      checks++; if (bus.clint_resp_yumi_o !== e_yumi) $display("FAIL rnd_yumi@%0d: got %0b want %0b", c, bus.clint_resp_yumi_o, e_yumi); else passed++;
      checks++; if (bus.req_resp_o !== bus.clint_resp_i) $display("FAIL rnd_resp@%0d: got %h want %h", c, bus.req_resp_o, bus.clint_resp_i); else passed++;
      checks++; if (bus.error_o !== err_m) $display("FAIL rnd_error@%0d: got %0b want %0b", c, bus.error_o, err_m); else passed++;
      checks++; if (int'(dut.count) !== q_m.size()) $display("FAIL rnd_count@%0d: got %0d want %0d", c, dut.count, q_m.size()); else passed++;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    rr_m = 0; err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rr_all();
    test_credit_block();
    test_yumi_owner();
    test_error_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
